// File: rtl/alu_op_sequencer.sv
`default_nettype none
// =============================================================================
// alu_op_sequencer : T0..T6 control-step sequencer for register-to-register ALU ops
// Revision: 1.0
// =============================================================================
module alu_op_sequencer #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 16,
   parameter int OPC_W      = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  mem_ready,
   input  logic [DATA_WIDTH-1:0] ir,
   output logic                  busy,
   output logic                  done,
   output logic                  illegal,
   output logic                  pc_out,
   output logic                  mar_in,
   output logic                  inc_pc,
   output logic                  pc_in,
   output logic                  read,
   output logic                  mdr_in,
   output logic                  mdr_out,
   output logic                  ir_in,
   output logic                  y_in,
   output logic                  z_in,
   output logic                  zlow_out,
   output logic                  zhigh_out,
   output logic                  hi_in,
   output logic                  lo_in,
   output logic [NUM_REGS-1:0]   reg_out,
   output logic [NUM_REGS-1:0]   reg_in,
   output logic [3:0]            alu_op
);
   localparam int RSEL_W = 4;
   localparam int RA_HI  = DATA_WIDTH - OPC_W - 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_T0 = 3'd1, S_T1 = 3'd2, S_T2 = 3'd3,
      S_T3   = 3'd4, S_T4 = 3'd5, S_T5 = 3'd6, S_T6 = 3'd7
   } state_t;

   typedef enum logic [1:0] {
      K_ILLEGAL = 2'd0, K_BINARY = 2'd1, K_MULDIV = 2'd2, K_UNARY = 2'd3
   } kind_t;

   state_t            r_state, w_next;
   kind_t             w_kind, r_kind;
   logic [3:0]        w_alu, r_alu;
   logic [OPC_W-1:0]  w_opc;
   logic [RSEL_W-1:0] w_ra, w_rb, w_rc, r_ra, r_rb, r_rc;
   logic              w_unused_ir;

   assign w_opc       = ir[DATA_WIDTH-1 -: OPC_W];
   assign w_ra        = ir[RA_HI -: RSEL_W];
   assign w_rb        = ir[RA_HI-RSEL_W -: RSEL_W];
   assign w_rc        = ir[RA_HI-2*RSEL_W -: RSEL_W];
   assign w_unused_ir = ^ir[RA_HI-3*RSEL_W:0];

   function automatic logic reg_ok(input logic [RSEL_W-1:0] r);
      return int'(r) < NUM_REGS;
   endfunction

   function automatic logic [NUM_REGS-1:0] onehot(input logic [RSEL_W-1:0] r);
      logic [NUM_REGS-1:0] v;
      v = '0;
      if (reg_ok(r)) v[r] = 1'b1;
      return v;
   endfunction

   // Decode of the live IR; only meaningful while in T3.
   always_comb begin
      w_kind = K_ILLEGAL;
      w_alu  = 4'd0;
      case (int'(w_opc))
         3, 4, 5, 6, 7, 8, 9, 10, 11: begin
            w_kind = K_BINARY;
            w_alu  = 4'(int'(w_opc) - 2);
         end
         16, 17: begin
            w_kind = K_MULDIV;
            w_alu  = 4'(int'(w_opc) - 6);
         end
         18, 19: begin
            w_kind = K_UNARY;
            w_alu  = 4'(int'(w_opc) - 6);
         end
         default: ;
      endcase
      if (!reg_ok(w_ra) || !reg_ok(w_rb) || (w_kind == K_BINARY && !reg_ok(w_rc)))
         w_kind = K_ILLEGAL;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_T0;
         S_T0:    w_next = S_T1;
         S_T1:    if (mem_ready) w_next = S_T2;
         S_T2:    w_next = S_T3;
         S_T3: begin
            case (w_kind)
               K_ILLEGAL: w_next = S_IDLE;
               K_UNARY:   w_next = S_T5;
               default:   w_next = S_T4;
            endcase
         end
         S_T4:    w_next = S_T5;
         S_T5:    w_next = (r_kind == K_MULDIV) ? S_T6 : S_IDLE;
         S_T6:    w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_kind  <= K_ILLEGAL;
         r_alu   <= 4'd0;
         r_ra    <= '0;
         r_rb    <= '0;
         r_rc    <= '0;
         done    <= 1'b0;
         illegal <= 1'b0;
      end else begin
         r_state <= w_next;
         done    <= (r_state == S_T5 && r_kind != K_MULDIV) || r_state == S_T6;
         illegal <= (r_state == S_T3) && (w_kind == K_ILLEGAL);
         if (r_state == S_T3) begin
            r_kind <= w_kind;
            r_alu  <= w_alu;
            r_ra   <= w_ra;
            r_rb   <= w_rb;
            r_rc   <= w_rc;
         end
      end
   end

   // Moore strobes; T3 reads the freshly loaded IR, later steps use the latched fields.
   always_comb begin
      {pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out,
       ir_in, y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in} = 14'd0;
      reg_out = '0;
      reg_in  = '0;
      alu_op  = 4'd0;
      busy    = (r_state != S_IDLE);
      case (r_state)
         S_T0: begin
            pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1;
         end
         S_T1: begin
            zlow_out = 1'b1; pc_in = 1'b1; read = 1'b1; mdr_in = 1'b1;
         end
         S_T2: begin
            mdr_out = 1'b1; ir_in = 1'b1;
         end
         S_T3: begin
            case (w_kind)
               K_BINARY: begin reg_out = onehot(w_rb); y_in = 1'b1; end
               K_MULDIV: begin reg_out = onehot(w_ra); y_in = 1'b1; end
               K_UNARY: begin
                  reg_out = onehot(w_rb);
                  alu_op  = w_alu;
                  z_in    = 1'b1;
               end
               default: ;
            endcase
         end
         S_T4: begin
            reg_out = onehot((r_kind == K_MULDIV) ? r_rb : r_rc);
            alu_op  = r_alu;
            z_in    = 1'b1;
         end
         S_T5: begin
            zlow_out = 1'b1;
            if (r_kind == K_MULDIV) lo_in = 1'b1;
            else                    reg_in = onehot(r_ra);
         end
         S_T6: begin
            zhigh_out = 1'b1; hi_in = 1'b1;
         end
         default: ;
      endcase
   end
endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// =============================================================================
// tb_alu_op_sequencer : directed + randomized bench with a per-instruction step-list model
// Revision: 1.0
// =============================================================================
module tb_alu_op_sequencer;
   logic        clk = 1'b0, reset = 1'b1, start = 1'b0, mem_ready = 1'b0;
   logic [31:0] ir = '0;
   logic        busy, done, illegal;
   logic        pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out;
   logic        ir_in, y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in;
   logic [15:0] reg_out, reg_in;
   logic [3:0]  alu_op;

   alu_op_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .mem_ready(mem_ready), .ir(ir),
      .busy(busy), .done(done), .illegal(illegal),
      .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .pc_in(pc_in),
      .read(read), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in),
      .y_in(y_in), .z_in(z_in), .zlow_out(zlow_out), .zhigh_out(zhigh_out),
      .hi_in(hi_in), .lo_in(lo_in), .reg_out(reg_out), .reg_in(reg_in),
      .alu_op(alu_op)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        fetch;
      logic [13:0] strb;
      logic [15:0] ro;
      logic [15:0] ri;
      logic [3:0]  alu;
   } step_t;

   localparam logic [13:0] PC_OUT = 14'h2000, MAR_IN = 14'h1000, INC_PC = 14'h0800,
                           PC_IN  = 14'h0400, READ   = 14'h0200, MDR_IN = 14'h0100,
                           MDR_OUT= 14'h0080, IR_IN  = 14'h0040, Y_IN   = 14'h0020,
                           Z_IN   = 14'h0010, ZLOW   = 14'h0008, ZHIGH  = 14'h0004,
                           HI_IN  = 14'h0002, LO_IN  = 14'h0001;

   step_t       q[$];
   logic        term_done = 1'b1, m_done = 1'b0, m_ill = 1'b0, last_ill = 1'b0;
   int          checks = 0, failures = 0, lat_cnt = 0, last_lat = 0, rd_cnt = 0, waits_left = 0;
   bit          ended = 0, rand_mode = 0, start_req = 0, chain_pending = 0;
   logic [31:0] next_ir = '0, chain_ir = '0;
   logic [31:0] R [16];
   logic [31:0] y = '0, hi = '0, lo = '0;
   logic [63:0] z = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic step_t mk(input logic [13:0] s, input int ro, input int ri,
                                input logic [3:0] alu, input logic f);
      step_t t;
      t = '0;
      t.fetch = f;
      t.strb  = s;
      t.alu   = alu;
      if (ro >= 0) t.ro[ro[3:0]] = 1'b1;
      if (ri >= 0) t.ri[ri[3:0]] = 1'b1;
      return t;
   endfunction

   // Expand one instruction into the list of control steps it must produce.
   task automatic begin_instr(input logic [31:0] i);
      int opc, ra, rb, rc;
      opc = int'(i[31:27]);
      ra  = int'(i[26:23]);
      rb  = int'(i[22:19]);
      rc  = int'(i[18:15]);
      q.push_back(mk(PC_OUT | MAR_IN | INC_PC | Z_IN, -1, -1, 4'd0, 1'b0));
      q.push_back(mk(ZLOW | PC_IN | READ | MDR_IN, -1, -1, 4'd0, 1'b1));
      q.push_back(mk(MDR_OUT | IR_IN, -1, -1, 4'd0, 1'b0));
      term_done = 1'b1;
      if (opc >= 3 && opc <= 11) begin
         q.push_back(mk(Y_IN, rb, -1, 4'd0, 1'b0));
         q.push_back(mk(Z_IN, rc, -1, 4'(opc - 2), 1'b0));
         q.push_back(mk(ZLOW, -1, ra, 4'd0, 1'b0));
      end else if (opc == 16 || opc == 17) begin
         q.push_back(mk(Y_IN, ra, -1, 4'd0, 1'b0));
         q.push_back(mk(Z_IN, rb, -1, 4'(opc - 6), 1'b0));
         q.push_back(mk(ZLOW | LO_IN, -1, -1, 4'd0, 1'b0));
         q.push_back(mk(ZHIGH | HI_IN, -1, -1, 4'd0, 1'b0));
      end else if (opc == 18 || opc == 19) begin
         q.push_back(mk(Z_IN, rb, -1, 4'(opc - 6), 1'b0));
         q.push_back(mk(ZLOW, -1, ra, 4'd0, 1'b0));
      end else begin
         q.push_back(mk(14'd0, -1, -1, 4'd0, 1'b0));
         term_done = 1'b0;
      end
   endtask

   function automatic logic [52:0] exp_vec();
      step_t t;
      t = '0;
      if (q.size() != 0) t = q[0];
      return {(q.size() != 0), m_done, m_ill, t.strb, t.ro, t.ri, t.alu};
   endfunction

   function automatic logic [52:0] dut_vec();
      return {busy, done, illegal, pc_out, mar_in, inc_pc, pc_in, read, mdr_in,
              mdr_out, ir_in, y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in,
              reg_out, reg_in, alu_op};
   endfunction

   function automatic logic [31:0] rand_ir();
      logic [4:0] o;
      int k;
      if ($urandom_range(0, 4) == 0) o = 5'($urandom);
      else begin
         k = int'($urandom_range(0, 12));
         o = (k < 9) ? 5'(k + 3) : 5'(k + 7);
      end
      return {o, 27'($urandom)};
   endfunction

   task automatic compare();
      chk("cycle", 64'(dut_vec()), 64'(exp_vec()));
      if (read) rd_cnt++;
      if (q.size() != 0) lat_cnt++;
      if (m_done || m_ill) begin
         last_lat = lat_cnt;
         last_ill = m_ill;
         lat_cnt  = 0;
         ended    = 1;
      end
   endtask

   // Small datapath driven by the DUT strobes, to tie step order to real results.
   task automatic dp_update();
      logic [31:0] bus;
      bus = '0;
      for (int i = 0; i < 16; i++) if (reg_out[i]) bus = R[i];
      if (zlow_out)  bus = z[31:0];
      if (zhigh_out) bus = z[63:32];
      if (z_in) begin
         case (alu_op)
            4'd1:    z = 64'(y + bus);
            4'd2:    z = 64'(y - bus);
            4'd10:   z = 64'(y) * 64'(bus);
            4'd11:   z = (bus != 0) ? {y % bus, y / bus} : 64'd0;
            4'd12:   z = 64'(-bus);
            4'd13:   z = 64'(~bus);
            default: z = '0;
         endcase
      end
      if (y_in) y = bus;
      for (int i = 0; i < 16; i++) if (reg_in[i]) R[i] = bus;
      if (lo_in) lo = bus;
      if (hi_in) hi = bus;
   endtask

   task automatic advance();
      logic nd, ni;
      nd = 1'b0;
      ni = 1'b0;
      if (q.size() == 0) begin
         if (start) begin_instr(ir);
      end else if (!(q[0].fetch && !mem_ready)) begin
         void'(q.pop_front());
         if (q.size() == 0) begin
            nd = term_done;
            ni = !term_done;
         end
      end
      m_done = nd;
      m_ill  = ni;
   endtask

   task automatic cycle();
      ended = 0;
      @(negedge clk);
      compare();
      dp_update();
      if (rand_mode) begin
         start     = ($urandom_range(0, 3) == 0);
         mem_ready = ($urandom_range(0, 3) != 0);
      end else begin
         start = start_req || (ended && chain_pending);
         if (ended && chain_pending) begin
            next_ir       = chain_ir;
            chain_pending = 0;
         end
         start_req = 0;
         mem_ready = 1'b1;
         if (q.size() != 0 && q[0].fetch && waits_left > 0) begin
            mem_ready = 1'b0;
            waits_left--;
         end
      end
      if (start && q.size() == 0) ir = rand_mode ? rand_ir() : next_ir;
      advance();
   endtask

   task automatic wait_end(input int budget);
      int n;
      n = 0;
      do begin
         cycle();
         n++;
      end while (!ended && n < budget);
      if (!ended) begin
         checks++;
         failures++;
         $display("FAIL timeout: no done/illegal within %0d cycles", budget);
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) R[i] = '0;
      @(negedge clk);
      chk("reset_outputs", 64'(dut_vec()), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // mul: HI:LO <- R2 * R6
      R[2] = 32'h22; R[6] = 32'h24;
      next_ir = 32'h8130_0000; start_req = 1;
      wait_end(40);
      chk("mul_latency", 64'(last_lat), 64'd7);
      chk("mul_done_pin", 64'(done), 64'd1);
      chk("mul_lo", 64'(lo), 64'h4C8);
      chk("mul_hi", 64'(hi), 64'd0);

      // add R1 <- R2 + R3, with a start pulse while busy
      R[2] = 32'd5; R[3] = 32'd7;
      next_ir = 32'h1891_8000; start_req = 1;
      repeat (3) cycle();
      start_req = 1;
      wait_end(40);
      chk("add_latency", 64'(last_lat), 64'd6);
      chk("add_done_pin", 64'(done), 64'd1);
      chk("add_r1", 64'(R[1]), 64'd12);

      // add with three cycles of memory wait in T1
      R[1] = '0; rd_cnt = 0; waits_left = 3;
      next_ir = 32'h1891_8000; start_req = 1;
      wait_end(40);
      chk("wait_latency", 64'(last_lat), 64'd9);
      chk("wait_read_cycles", 64'(rd_cnt), 64'd4);
      chk("wait_r1", 64'(R[1]), 64'd12);

      // illegal opcode 31
      next_ir = 32'hF800_0000; start_req = 1;
      wait_end(40);
      chk("ill_latency", 64'(last_lat), 64'd4);
      chk("ill_model_pulse", 64'(last_ill), 64'd1);
      chk("ill_pulse_pin", 64'(illegal), 64'd1);
      chk("ill_busy_pin", 64'(busy), 64'd0);

      // reset during T4 of mul
      next_ir = 32'h8130_0000; start_req = 1;
      repeat (6) cycle();
      chk("t4_alu_op", 64'(alu_op), 64'd10);
      chk("t4_reg_out", 64'(reg_out), 64'h0040);
      #2 reset = 1'b1;
      #1 chk("reset_mid", 64'(dut_vec()), 64'd0);
      q.delete();
      m_done = 1'b0; m_ill = 1'b0; lat_cnt = 0; start = 1'b0;
      cycle();
      reset = 1'b0;

      // neg R1 <- -R2, then a back-to-back add started in the done cycle
      next_ir = 32'h9090_0000; start_req = 1;
      chain_ir = 32'h1891_8000; chain_pending = 1;
      wait_end(40);
      chk("neg_latency", 64'(last_lat), 64'd5);
      chk("neg_r1", 64'(R[1]), 64'hFFFF_FFFB);
      cycle();
      chk("b2b_busy", 64'(busy), 64'd1);
      wait_end(40);
      chk("b2b_latency", 64'(last_lat), 64'd6);

      // randomized traffic
      rand_mode = 1;
      repeat (800) cycle();
      rand_mode = 0;
      if (q.size() != 0) wait_end(60);
      repeat (2) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
